// File: rtl/tick_generator_pkg.sv
// ============================================================================
// tick_generator_pkg : default clock rates and shared types for the timebase
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package tick_generator_pkg;

  localparam int c_DEF_CLK_HZ      = 100_000_000;
  localparam int c_DEF_TICK_HZ     = 1;
  localparam int c_DEF_FAST_FACTOR = 60;
  localparam int c_DEF_SCAN_HZ     = 1000;
  localparam int c_DEF_SCAN_DIGITS = 4;

  // Registered outputs of the main (seconds) divider.
  typedef struct packed {
    logic tick;
    logic half_tick;
    logic sq;
  } main_out_t;

  // Counter width for a modulus n; never narrower than one bit.
  function automatic int width_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_generator_mod_counter.sv
// ============================================================================
// mod_counter : counts 0..last with enable and synchronous clear
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] last,
  output logic [W-1:0] count,
  output logic         wrap
);

  logic [W-1:0] r_count;
  logic         w_at_last;

  assign w_at_last = (r_count == last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      if (w_at_last) r_count <= '0;
      else           r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;
  assign wrap  = w_at_last && en;

endmodule

`default_nettype wire

// File: rtl/tick_generator.sv
// ============================================================================
// tick_generator : 1 Hz tick / square wave / blink pulse plus display scan
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_generator
  import tick_generator_pkg::*;
#(
  parameter int CLK_HZ      = c_DEF_CLK_HZ,
  parameter int TICK_HZ     = c_DEF_TICK_HZ,
  parameter int FAST_FACTOR = c_DEF_FAST_FACTOR,
  parameter int SCAN_HZ     = c_DEF_SCAN_HZ,
  parameter int SCAN_DIGITS = c_DEF_SCAN_DIGITS,
  parameter int IDX_W       = width_for(SCAN_DIGITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             fast,
  output logic             tick,
  output logic             half_tick,
  output logic             sq,
  output logic             scan_tick,
  output logic [IDX_W-1:0] scan_idx
);

  localparam int c_DIV      = CLK_HZ / TICK_HZ;
  localparam int c_FAST_DIV = c_DIV / FAST_FACTOR;
  localparam int c_SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int c_MAIN_W   = width_for(c_DIV);
  localparam int c_SCAN_W   = width_for(c_SCAN_DIV);

  localparam logic [c_MAIN_W-1:0] c_SLOW_LAST = c_MAIN_W'(c_DIV - 1);
  localparam logic [c_MAIN_W-1:0] c_FAST_LAST = c_MAIN_W'(c_FAST_DIV - 1);
  localparam logic [c_MAIN_W-1:0] c_SLOW_HM1  = c_MAIN_W'(c_DIV / 2 - 1);
  localparam logic [c_MAIN_W-1:0] c_FAST_HM1  = c_MAIN_W'(c_FAST_DIV / 2 - 1);
  localparam logic [c_SCAN_W-1:0] c_SCAN_LAST = c_SCAN_W'(c_SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]    c_IDX_LAST  = IDX_W'(SCAN_DIGITS - 1);

  if (c_DIV < 2 || c_FAST_DIV < 2 || c_SCAN_DIV < 2 || SCAN_DIGITS < 2) begin : g_bad_params
    $fatal(1, "tick_generator: DIV, FAST_DIV, SCAN_DIV and SCAN_DIGITS must all be >= 2");
  end

  // ---------------------------------------------------------------- main path
  logic [c_MAIN_W-1:0] w_cnt;
  logic [c_MAIN_W-1:0] w_last;
  logic [c_MAIN_W-1:0] w_half_m1;
  logic                w_main_wrap;
  logic                r_fast_q;
  main_out_t           r_main;

  // The period length only changes at a wrap or clear, so cnt never overshoots.
  assign w_last    = r_fast_q ? c_FAST_LAST : c_SLOW_LAST;
  assign w_half_m1 = r_fast_q ? c_FAST_HM1  : c_SLOW_HM1;

  mod_counter #(
    .W (c_MAIN_W)
  ) u_main_div (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clr   (clr),
    .last  (w_last),
    .count (w_cnt),
    .wrap  (w_main_wrap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main   <= '0;
      r_fast_q <= 1'b0;
    end else if (clr) begin
      r_main   <= '0;
      r_fast_q <= fast;
    end else if (en) begin
      if (w_main_wrap) begin
        r_main.tick      <= 1'b1;
        r_main.half_tick <= 1'b1;
        r_main.sq        <= 1'b0;
        r_fast_q         <= fast;
      end else if (w_cnt == w_half_m1) begin
        r_main.tick      <= 1'b0;
        r_main.half_tick <= 1'b1;
        r_main.sq        <= 1'b1;
      end else begin
        r_main.tick      <= 1'b0;
        r_main.half_tick <= 1'b0;
      end
    end else begin
      r_main.tick      <= 1'b0;
      r_main.half_tick <= 1'b0;
    end
  end

  assign tick      = r_main.tick;
  assign half_tick = r_main.half_tick;
  assign sq        = r_main.sq;

  // ---------------------------------------------------------------- scan path
  logic [c_SCAN_W-1:0] w_scan_cnt;
  logic                w_scan_wrap;
  logic                r_scan_tick;
  logic [IDX_W-1:0]    r_scan_idx;

  mod_counter #(
    .W (c_SCAN_W)
  ) u_scan_div (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .clr   (1'b0),
    .last  (c_SCAN_LAST),
    .count (w_scan_cnt),
    .wrap  (w_scan_wrap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scan_tick <= 1'b0;
      r_scan_idx  <= '0;
    end else begin
      r_scan_tick <= w_scan_wrap;
      if (w_scan_wrap) begin
        if (r_scan_idx == c_IDX_LAST) r_scan_idx <= '0;
        else                          r_scan_idx <= r_scan_idx + IDX_W'(1);
      end
    end
  end

  assign scan_tick = r_scan_tick;
  assign scan_idx  = r_scan_idx;

  logic w_unused;
  assign w_unused = ^w_scan_cnt;

endmodule

`default_nettype wire
